// File: rtl/regfile_access_sequencer_pkg.sv
// Shared encodings for the file-register access sequencer: op codes, FSM states,
// STATUS bit positions and the INDF file address.
package regfile_access_sequencer_pkg;

  localparam int unsigned F_W    = 7;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam int unsigned STATUS_IRP = 7;
  localparam int unsigned STATUS_RP1 = 6;
  localparam int unsigned STATUS_RP0 = 5;

  localparam logic [F_W-1:0] INDF_F = 7'h00;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_RMW   = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_addr_gen.sv
// Combinational file-register address resolution: banked direct address or
// IRP:FSR indirect address, plus the INDF-through-FSR-to-INDF flag.
module regfile_addr_gen
  import regfile_access_sequencer_pkg::*;
(
  input  logic [F_W-1:0]    i_f,
  input  logic              i_irp,
  input  logic [1:0]        i_rp,
  input  logic [DATA_W-1:0] i_fsr,
  output logic [ADDR_W-1:0] o_addr_c,
  output logic              o_indf_self_c
);

  logic w_indirect;

  assign w_indirect    = (i_f == INDF_F);
  assign o_addr_c      = w_indirect ? {i_irp, i_fsr} : {i_rp, i_f};
  // FSR pointing back at INDF in either bank is a self-reference
  assign o_indf_self_c = w_indirect && (i_fsr[F_W-1:0] == INDF_F);

endmodule

// File: rtl/regfile_access_sequencer.sv
// Initiator for the file-register bus: resolves the f field, issues read/write
// strobes to the responder, waits out read latency and trades data with the ALU.
module regfile_access_sequencer
  import regfile_access_sequencer_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [F_W-1:0]    req_f,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] status_val,
  input  logic [DATA_W-1:0] fsr_val,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_rd_en,
  output logic              rf_wr_en,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] alu_operand,
  output logic              alu_operand_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_result_valid,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data
);

  state_e             r_state;
  state_e             w_state_nxt;
  op_e                r_op;
  logic               r_self;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_self;
  logic               w_accept;
  logic               w_capture;
  logic               w_load_result;
  logic               w_unused_status;

  assign w_unused_status = &{1'b0, status_val[STATUS_RP0-1:0]};

  regfile_addr_gen u_addr_gen (
    .i_f           (req_f),
    .i_irp         (status_val[STATUS_IRP]),
    .i_rp          (status_val[STATUS_RP1:STATUS_RP0]),
    .i_fsr         (fsr_val),
    .o_addr_c      (w_addr),
    .o_indf_self_c (w_self)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and state-decoded strobes; every strobe is masked during reset
  always_comb begin
    w_state_nxt       = r_state;
    req_ready         = 1'b0;
    rf_rd_en          = 1'b0;
    rf_wr_en          = 1'b0;
    alu_operand_valid = 1'b0;
    resp_valid        = 1'b0;
    w_accept          = 1'b0;
    w_capture         = 1'b0;
    w_load_result     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          w_accept = 1'b1;
          case (op_e'(req_op))
            OP_READ, OP_RMW: w_state_nxt = ST_READ;
            OP_WRITE:        w_state_nxt = ST_WRITE;
            default:         w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_READ: begin
        rf_rd_en    = !rst && !r_self;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = (r_op == OP_RMW) ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: begin
        alu_operand_valid = !rst;
        if (alu_result_valid) begin
          w_load_result = 1'b1;
          w_state_nxt   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        rf_wr_en    = !rst && !r_self;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        resp_valid  = !rst;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction datapath: address/data captured at acceptance, read value at end of WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_addr     <= '0;
      rf_wdata    <= '0;
      alu_operand <= '0;
      resp_data   <= '0;
      r_op        <= OP_NOP;
      r_self      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        rf_addr   <= w_addr;
        r_self    <= w_self;
        r_op      <= op_e'(req_op);
        resp_data <= '0;
        if (op_e'(req_op) == OP_WRITE) rf_wdata <= req_wdata;
      end
      if (r_state == ST_READ)                      r_cnt <= CNT_W'(RD_LATENCY - 1);
      else if (r_state == ST_WAIT && r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
      if (w_capture) begin
        alu_operand <= r_self ? '0 : rf_rdata;
        resp_data   <= r_self ? '0 : rf_rdata;
      end
      if (w_load_result) rf_wdata <= alu_result;
    end
  end

endmodule
